// File: rtl/counter_uart_reporter.sv
// rtl/counter_uart_reporter.sv - periodic/on-demand UART report of DRAM tester pass/fail counters
// Sends "P=hhhh F=hhhh\r\n" at 8N1 from a snapshot taken when the frame is triggered.
module counter_uart_reporter #(
    parameter int BAUD_DIV    = 760,
    parameter int REPORT_LOG2 = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pass_counter,
    input  logic [15:0] fail_counter,
    input  logic        report_req,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, FINISH} state_t;

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    state_t                 state, state_next;
    logic [REPORT_LOG2-1:0] timer;
    logic [15:0]            baud_cnt;
    logic [2:0]             bit_cnt;
    logic [3:0]             byte_idx;
    logic [7:0]             shreg;
    logic [15:0]            pass_snap;
    logic [15:0]            fail_snap;
    logic [7:0]             cur_byte;
    logic                   trigger;
    logic                   baud_tick;

    // The wrap edge is the clock on which the timer holds all-ones.
    assign trigger   = report_req | (&timer);
    assign baud_tick = (baud_cnt == 16'd0);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            4'd0:    cur_byte = 8'h50;
            4'd1:    cur_byte = 8'h3D;
            4'd2:    cur_byte = hex_ascii(pass_snap[15:12]);
            4'd3:    cur_byte = hex_ascii(pass_snap[11:8]);
            4'd4:    cur_byte = hex_ascii(pass_snap[7:4]);
            4'd5:    cur_byte = hex_ascii(pass_snap[3:0]);
            4'd6:    cur_byte = 8'h20;
            4'd7:    cur_byte = 8'h46;
            4'd8:    cur_byte = 8'h3D;
            4'd9:    cur_byte = hex_ascii(fail_snap[15:12]);
            4'd10:   cur_byte = hex_ascii(fail_snap[11:8]);
            4'd11:   cur_byte = hex_ascii(fail_snap[7:4]);
            4'd12:   cur_byte = hex_ascii(fail_snap[3:0]);
            4'd13:   cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = LOAD;
            LOAD:    state_next = START;
            START:   if (baud_tick) state_next = DATA;
            DATA:    if (baud_tick && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (baud_tick) state_next = (byte_idx < 4'd14) ? LOAD : FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer <= '0;
        else        timer <= timer + 1'b1;
    end

    // txd is driven one clock ahead from the current state so it stays a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd       <= 1'b1;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 4'd0;
            shreg     <= 8'd0;
            pass_snap <= 16'd0;
            fail_snap <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    byte_idx <= 4'd0;
                    if (trigger) begin
                        pass_snap <= pass_counter;
                        fail_snap <= fail_counter;
                    end
                end
                LOAD: begin
                    shreg    <= cur_byte;
                    baud_cnt <= BAUD_RELOAD;
                    txd      <= 1'b0;
                end
                START: begin
                    if (baud_tick) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= 3'd0;
                        txd      <= shreg[0];
                        shreg    <= shreg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    txd <= 1'b1;
                    if (baud_tick) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (byte_idx < 4'd14) byte_idx <= byte_idx + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: txd <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_uart_reporter.sv
// tb/tb_counter_uart_reporter.sv - directed self-checking bench for counter_uart_reporter
module tb_counter_uart_reporter;

    localparam int BAUD_DIV    = 4;
    localparam int REPORT_LOG2 = 10;
    localparam int BYTE_CLKS   = 10 * BAUD_DIV + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pass_counter = 16'h0;
    logic [15:0] fail_counter = 16'h0;
    logic        report_req = 1'b0;
    logic        txd;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int rx_bad = 0;
    int rx_t [15];
    logic [7:0] rx_bytes [15];
    logic [7:0] exp_b [15];

    counter_uart_reporter #(.BAUD_DIV(BAUD_DIV), .REPORT_LOG2(REPORT_LOG2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pass_counter(pass_counter),
        .fail_counter(fail_counter),
        .report_req(report_req),
        .txd(txd),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        report_req = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_req();
        report_req = 1'b1;
        @(negedge clk);
        report_req = 1'b0;
    endtask

    task automatic rx_frame();
        rx_bad = 0;
        for (int b = 0; b < 15; b++) begin
            int w = 0;
            while (txd !== 1'b0 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                check("rx_start_timeout", 32'd0, 32'd1);
                return;
            end
            rx_t[b] = cyc;
            repeat (BAUD_DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD_DIV) @(negedge clk);
                rx_bytes[b][i] = txd;
            end
            repeat (BAUD_DIV) @(negedge clk);
            if (txd !== 1'b1) rx_bad++;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy === 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_expected(input logic [15:0] p, input logic [15:0] f);
        string hx = "0123456789ABCDEF";
        exp_b[0]  = 8'h50;
        exp_b[1]  = 8'h3D;
        exp_b[2]  = hx[p[15:12]];
        exp_b[3]  = hx[p[11:8]];
        exp_b[4]  = hx[p[7:4]];
        exp_b[5]  = hx[p[3:0]];
        exp_b[6]  = 8'h20;
        exp_b[7]  = 8'h46;
        exp_b[8]  = 8'h3D;
        exp_b[9]  = hx[f[15:12]];
        exp_b[10] = hx[f[11:8]];
        exp_b[11] = hx[f[7:4]];
        exp_b[12] = hx[f[3:0]];
        exp_b[13] = 8'h0D;
        exp_b[14] = 8'h0A;
    endtask

    task automatic check_frame(input string tag);
        int bad_gap = 0;
        for (int b = 0; b < 15; b++)
            check($sformatf("%s_byte%0d", tag, b), {24'h0, rx_bytes[b]}, {24'h0, exp_b[b]});
        for (int b = 1; b < 15; b++)
            if (rx_t[b] - rx_t[b-1] != BYTE_CLKS) bad_gap++;
        check({tag, "_gap"}, bad_gap, 0);
        check({tag, "_stop"}, rx_bad, 0);
    endtask

    task automatic watch_idle(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [119:0] lit;
        int n;
        int bad;
        int t_k;

        // Reset values, idle line, then the first timer-driven frame
        pass_counter = 16'hA5C3;
        fail_counter = 16'h0F1E;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        n = 0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            n++;
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_1000", bad, 0);
        while (busy !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("timer_first_trigger", n, 1024);
        rx_frame();
        set_expected(16'hA5C3, 16'h0F1E);
        check_frame("timer");
        wait_idle();

        // Immediate report with literal expected bytes, busy length and done pulse
        do_reset();
        pass_counter = 16'h1234;
        fail_counter = 16'h00AB;
        repeat (2) @(negedge clk);
        busy_cnt = 0;
        done_cnt = 0;
        pulse_req();
        t_k = cyc;
        check("load_busy", busy, 1);
        check("load_txd", txd, 1);
        rx_frame();
        check("fall_latency", rx_t[0] - t_k, 1);
        lit = 120'h503D3132333420463D303041420D0A;
        for (int b = 0; b < 15; b++) exp_b[b] = lit[119 - 8*b -: 8];
        check_frame("req");
        wait_idle();
        check("busy_clocks", busy_cnt, 616);
        check("done_pulses", done_cnt, 1);

        // Input change mid-frame must not leak into the snapshot
        do_reset();
        pass_counter = 16'h0001;
        fail_counter = 16'h0000;
        repeat (2) @(negedge clk);
        pulse_req();
        fork
            rx_frame();
            begin
                repeat (3 * BYTE_CLKS + 10) @(negedge clk);
                pass_counter = 16'hFFFF;
            end
        join
        set_expected(16'h0001, 16'h0000);
        check_frame("snap_old");
        wait_idle();
        repeat (2) @(negedge clk);
        pulse_req();
        rx_frame();
        set_expected(16'hFFFF, 16'h0000);
        check_frame("snap_new");
        wait_idle();
        watch_idle("wrap_dropped", 600);

        // Request during a frame is dropped
        do_reset();
        pass_counter = 16'h5A5A;
        fail_counter = 16'h1111;
        repeat (2) @(negedge clk);
        busy_cnt = 0;
        done_cnt = 0;
        pulse_req();
        fork
            rx_frame();
            begin
                repeat (5 * BYTE_CLKS + 10) @(negedge clk);
                pulse_req();
            end
        join
        set_expected(16'h5A5A, 16'h1111);
        check_frame("busy_req");
        wait_idle();
        watch_idle("no_second_frame", 200);
        check("busy_req_done", done_cnt, 1);

        // Reset in the start bit of byte 7 aborts the frame
        do_reset();
        pass_counter = 16'h0246;
        fail_counter = 16'h8ACE;
        repeat (2) @(negedge clk);
        pulse_req();
        repeat (7 * BYTE_CLKS + 2) @(negedge clk);
        check("byte7_start_txd", txd, 0);
        rst_n = 1'b0;
        #1;
        check("abort_txd", txd, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_idle("post_abort_idle", 500);
        pulse_req();
        rx_frame();
        set_expected(16'h0246, 16'h8ACE);
        check_frame("post_abort");
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_uart_reporter.md
COUNTER_UART_REPORTER -- requirements
Module: counter_uart_reporter

Interface
REQ-001 Parameter BAUD_DIV, default 760: clocks per UART bit, legal range 2..65535.
REQ-002 Parameter REPORT_LOG2, default 24: a periodic report fires every 2^REPORT_LOG2 clocks, legal range 4..31.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 pass_counter  input  16  pass count from the DRAM tester.
REQ-006 fail_counter  input  16  fail count from the DRAM tester.
REQ-007 report_req  input  1  single-cycle request for an immediate report.
REQ-008 txd  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a report frame is being sent.
REQ-010 done  output  1  one-cycle pulse after the last stop bit of a report.

Function
REQ-011 The report SHALL be 15 ASCII bytes: 'P','=',4 hex digits of pass,' ','F','=',4 hex digits of fail,0x0D,0x0A.
REQ-012 Hex digits SHALL be uppercase ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), MS nibble first.
REQ-013 The free-running timer SHALL be REPORT_LOG2 bits wide and wrap from all-ones to zero; the wrap edge is a timer trigger.
REQ-014 Trigger = report_req OR timer trigger, sampled at rising edge k while busy=0.
REQ-015 At edge k both counters SHALL be snapshotted together into internal registers, and busy SHALL go 1.
REQ-016 Later input changes SHALL NOT affect the frame in progress.
REQ-017 Triggers seen while busy=1 SHALL be dropped, not queued; the timer keeps counting.
REQ-018 The FSM SHALL have these states: IDLE, LOAD (select byte, 1 clock), START, DATA (8 bits), STOP, FINISH.
REQ-019 FSM transitions SHALL be: IDLE -> LOAD on a trigger; LOAD -> START; START -> DATA; DATA -> STOP after bit 7; STOP -> LOAD if byte index < 14, else STOP -> FINISH; FINISH -> IDLE.
REQ-020 START, each DATA bit and STOP SHALL each last exactly BAUD_DIV clocks, timed by a baud counter reloaded on every bit boundary.
REQ-021 txd SHALL fall at edge k+1, when START is entered from LOAD; txd is registered and glitch-free.
REQ-022 There SHALL be no idle gap between bytes except the one LOAD clock after each stop bit, during which txd stays 1.
REQ-023 Frame length from the txd falling edge to the end of the final stop bit SHALL be 15*(10*BAUD_DIV+1)-1 clocks.
REQ-024 In FINISH, done SHALL be 1 for exactly one clock and busy SHALL remain 1; busy clears on entry to IDLE.
REQ-025 The byte index SHALL be 4 bits, run 0..14, and reset to 0 in IDLE.
REQ-026 If a trigger coincides with the clock that enters IDLE from FINISH, it SHALL be ignored, because busy is still 1 on that edge.

Reset
REQ-027 While rst_n=0, outputs SHALL be forced asynchronously to txd=1, busy=0, done=0.
REQ-028 While rst_n=0, internal state SHALL be forced asynchronously to FSM=IDLE, timer=0, baud counter=0, byte index=0, snapshots=0.
REQ-029 Reset mid-frame SHALL abort the frame: txd returns high immediately, and after release no partial frame resumes.
REQ-030 After reset release, the first timer trigger SHALL occur 2^REPORT_LOG2 clocks after the first active edge.

Verification (BAUD_DIV=4, REPORT_LOG2=10 in bench)
REQ-031 Reset, no triggers -> txd=1, busy=0, done=0 throughout the first 1000 clocks.
REQ-032 pass=16'h1234, fail=16'h00AB, report_req pulse -> bytes 50 3D 31 32 33 34 20 46 3D 30 30 41 42 0D 0A decoded; busy high 616 clocks; one done pulse.
REQ-033 Change pass to 16'hFFFF at byte 3 of a frame started with pass=16'h0001 -> frame still shows "0001"; next report shows "FFFF".
REQ-034 report_req pulsed again at frame byte 5 -> no second frame; exactly one done pulse.
REQ-035 No report_req, idle -> a frame starts at timer wrap (clock 1024); a report_req frame spanning the next wrap -> that timer trigger is dropped.
REQ-036 rst_n low during byte 7 -> txd=1 within the same clock and busy=0; after release the line stays idle until the next trigger.
